// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption engine: one Feistel round per clock with the subkeys generated in reverse on the fly.
// Optional macro DES_ZEROIZE_EN clears key material and plaintext on the output handshake.
module des_decrypt_iter #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_key,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // Permutation tables use 1-based bit numbers counted from the MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                               37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // S-box n occupies entries n*64 .. n*64+63, addressed as row*16 + column.
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    y = 64'd0;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = 56'd0;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = 48'd0;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] subkey);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    logic [8:0]  a;
    x = 48'd0;
    for (int k = 0; k < 48; k++) x[6'(47 - k)] = r[5'(32 - E_T[k])];
    x = x ^ subkey;
    s = 32'd0;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(47 - 6 * j) -: 6];
      a = {3'(j), b[5], b[0], b[4:1]};
      s[5'(31 - 4 * j) -: 4] = 4'(SBOX[a]);
    end
    y = 32'd0;
    for (int k = 0; k < 32; k++) y[5'(31 - k)] = s[5'(32 - P_T[k])];
    return y;
  endfunction

  state_t      state_r;
  logic [4:0]  round_r;
  logic [31:0] l_r, r_r;
  logic [27:0] c_r, d_r;
  logic [31:0] r_new_s;
  logic [27:0] c_next_s, d_next_s;
  logic [63:0] ip_s, plain_s;
  logic [55:0] pc1_s;
  logic        last_s;

  assign in_ready = (state_r == IDLE);
  assign ip_s     = perm_ip(in_data);
  assign pc1_s    = perm_pc1(in_key);
  assign last_s   = (round_r == 5'(ROUNDS));
  assign r_new_s  = l_r ^ feistel(r_r, perm_pc2({c_r, d_r}));
  assign plain_s  = perm_fp({r_new_s, r_r});

  // Right-rotate C/D to step the subkey from K(17-i) to K(16-i); undoes the encrypt-side left shift.
  always_comb begin
    c_next_s = c_r;
    d_next_s = d_r;
    if (!last_s) begin
      case (round_r)
        5'd1, 5'd8, 5'd15: begin
          c_next_s = {c_r[0], c_r[27:1]};
          d_next_s = {d_r[0], d_r[27:1]};
        end
        5'd16: begin
          c_next_s = c_r;
          d_next_s = d_r;
        end
        default: begin
          c_next_s = {c_r[1:0], c_r[27:2]};
          d_next_s = {d_r[1:0], d_r[27:2]};
        end
      endcase
    end else begin
      c_next_s = c_r;
      d_next_s = d_r;
    end
  end

  // Control FSM and round datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      round_r   <= 5'd0;
      l_r       <= 32'd0;
      r_r       <= 32'd0;
      c_r       <= 28'd0;
      d_r       <= 28'd0;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            {l_r, r_r} <= ip_s;
            {c_r, d_r} <= pc1_s;
            round_r    <= 5'd1;
            busy       <= 1'b1;
            state_r    <= ROUND;
          end
        end
        ROUND: begin
          l_r <= r_r;
          r_r <= r_new_s;
          c_r <= c_next_s;
          d_r <= d_next_s;
          if (last_s) begin
            out_data  <= plain_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            round_r <= round_r + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
`ifdef DES_ZEROIZE_EN
            out_data <= 64'd0;
            l_r      <= 32'd0;
            r_r      <= 32'd0;
            c_r      <= 28'd0;
            d_r      <= 28'd0;
`endif
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed known-answer bench for des_decrypt_iter: latency, back-to-back, backpressure, busy-ignore, reset, zeroize.
module tb_des_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_key = 64'd0;
  logic [63:0] in_data = 64'd0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] CT2  = 64'h0000000000000000;
  localparam logic [63:0] PT2  = 64'h8787878787878787;
  localparam logic [63:0] KEY3 = 64'h0101010101010101;
  localparam logic [63:0] CT3  = 64'h8000000000000000;
  localparam logic [63:0] PT3  = 64'h95F8A5E5DD31D900;

  des_decrypt_iter #(.ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one block for a single accept edge, then scrambles the inputs.
  task automatic send(input logic [63:0] k, input logic [63:0] d);
    check("accept_ready", 64'(in_ready), 64'd1);
    in_key = k;
    in_data = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_key = ~k;
    in_data = ~d;
  endtask

  task automatic wait_valid(output int e);
    e = 0;
    while (!out_valid && e < 40) begin
      tick();
      e++;
    end
  endtask

  // Full block with out_ready high: checks plaintext, latency and in_ready-low span.
  task automatic run_block(input string tag, input logic [63:0] k, input logic [63:0] d,
                           input logic [63:0] exp);
    int e, lo, lat;
    logic [63:0] got;
    logic seen;
    e = 0; lo = 0; lat = -1; seen = 1'b0; got = 64'hx;
    out_ready = 1'b1;
    send(k, d);
    for (int it = 0; it < 40; it++) begin
      if (in_ready) break;
      lo++;
      if (out_valid && !seen) begin
        seen = 1'b1;
        got = out_data;
        lat = e;
      end
      tick();
      e++;
    end
    check({tag, "_data"}, got, exp);
    check({tag, "_latency"}, 64'(lat), 64'd16);
    check({tag, "_ready_low"}, 64'(lo), 64'd17);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int e;
    int e2;
    logic [63:0] held;

    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Known answer, followed by the post-handshake out_data value.
    run_block("kat1", KEY1, CT1, PT1);
`ifdef DES_ZEROIZE_EN
    check("zeroize_out_data", out_data, 64'd0);
`else
    check("hold_out_data", out_data, PT1);
`endif

    // Back-to-back blocks.
    run_block("kat2", KEY2, CT2, PT2);
    run_block("kat3", KEY3, CT3, PT3);

    // Backpressure.
    out_ready = 1'b0;
    send(KEY1, CT1);
    check("bp_busy", 64'(busy), 64'd1);
    wait_valid(e);
    check("bp_latency", 64'(e), 64'd16);
    held = out_data;
    check("bp_data", held, PT1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_data_hold", out_data, held);
      check("bp_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_valid_clear", 64'(out_valid), 64'd0);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_busy_clear", 64'(busy), 64'd0);

    // Foreign in_valid during round 8 must be ignored.
    send(KEY1, CT1);
    repeat (7) tick();
    in_valid = 1'b1;
    in_key = KEY2;
    in_data = CT3;
    tick();
    tick();
    in_valid = 1'b0;
    wait_valid(e2);
    check("ign_latency", 64'(e2 + 9), 64'd16);
    check("ign_data", out_data, PT1);
    tick();
    check("ign_ready_back", 64'(in_ready), 64'd1);

    // Asynchronous reset during round 10.
    out_ready = 1'b0;
    send(KEY2, CT2);
    repeat (9) tick();
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", out_data, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_block("post_rst", KEY1, CT1, PT1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
